// File: rtl/gsim_pkg.sv
// Shared constants, state encoding and row tag for the Gauss-Seidel row fetch path.
package gsim_pkg;
    localparam int ROW_W      = 256;
    localparam int ADDR_W     = 10;
    localparam int MAT_STRIDE = 17;
    localparam int B_OFFSET   = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [4:0] mat;
        logic [3:0] iter;
        logic [3:0] idx;
        logic       is_b;
    } row_tag_t;

    localparam int TAG_W = $bits(row_tag_t);

    function automatic logic [ADDR_W-1:0] row_addr(input logic [4:0] mat, input logic is_b,
                                                   input logic [3:0] idx);
        logic [ADDR_W-1:0] offset;
        offset = is_b ? ADDR_W'(B_OFFSET) : ADDR_W'(idx);
        return ADDR_W'(mat) * ADDR_W'(MAT_STRIDE) + offset;
    endfunction
endpackage

// File: rtl/gsim_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is visible once count is non-zero.
module gsim_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    // A push at full is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/gsim_row_fetcher.sv
// Issues the b row then NITER passes of ROWS rows per matrix under credit control and
// buffers the in-order returns with their tags for the compute engine.
module gsim_row_fetcher
    import gsim_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NITER = 16,
    parameter int ROWS  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [4:0]        i_matrix_num,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_rreq,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_rrdy,
    input  logic [ROW_W-1:0]  i_mem_dout,
    input  logic              i_mem_dout_vld,
    output logic              o_row_vld,
    input  logic              i_row_rdy,
    output logic [ROW_W-1:0]  o_row_data,
    output logic [4:0]        o_row_mat,
    output logic [3:0]        o_row_iter,
    output logic [3:0]        o_row_idx,
    output logic              o_row_is_b
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t                    state, state_nx;
    logic [4:0]                num_mat, cur_mat;
    logic [3:0]                cur_iter, cur_idx;
    logic                      cur_is_b, all_issued;
    logic [CNT_W-1:0]          credits, credits_nx, tag_count, row_count;
    logic                      rreq;
    logic [ADDR_W-1:0]         addr;
    row_tag_t                  req_tag, ret_tag, head_tag;
    logic [ROW_W-1:0]          head_data;
    logic [TAG_W+ROW_W-1:0]    row_rdata;
    logic                      accept, ret, row_vld, pop, load;

    assign accept     = rreq && i_mem_rrdy;
    assign ret        = i_mem_dout_vld && (state == S_RUN || state == S_DRAIN);
    assign row_vld    = (row_count != '0);
    assign pop        = row_vld && i_row_rdy;
    assign credits_nx = credits - CNT_W'(accept) + CNT_W'(pop);
    // A new request reserves a credit when raised, so it can wait on rrdy safely.
    assign load       = (state == S_RUN) && !all_issued && (!rreq || accept) && (credits_nx != '0);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (i_start) state_nx = (i_matrix_num == '0) ? S_DONE : S_RUN;
            S_RUN:   if (accept && all_issued) state_nx = S_DRAIN;
            // Full credit means nothing outstanding, nothing buffered and the last row popped.
            S_DRAIN: if (credits == CNT_W'(DEPTH) && tag_count == '0) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= S_IDLE;
            credits    <= CNT_W'(DEPTH);
            num_mat    <= '0;
            cur_mat    <= '0;
            cur_iter   <= '0;
            cur_idx    <= '0;
            cur_is_b   <= 1'b0;
            all_issued <= 1'b0;
            rreq       <= 1'b0;
            addr       <= '0;
        end else begin
            state   <= state_nx;
            credits <= credits_nx;
            if (state == S_IDLE && i_start) begin
                num_mat    <= i_matrix_num;
                cur_mat    <= '0;
                cur_iter   <= '0;
                cur_idx    <= '0;
                cur_is_b   <= 1'b1;
                all_issued <= 1'b0;
            end
            if (load) begin
                rreq <= 1'b1;
                addr <= row_addr(cur_mat, cur_is_b, cur_idx);
                if (cur_is_b) begin
                    cur_is_b <= 1'b0;
                end else if (cur_idx == 4'(ROWS - 1)) begin
                    cur_idx <= '0;
                    if (cur_iter == 4'(NITER - 1)) begin
                        cur_iter <= '0;
                        cur_is_b <= 1'b1;
                        cur_mat  <= cur_mat + 5'd1;
                        if (cur_mat == num_mat - 5'd1) all_issued <= 1'b1;
                    end else begin
                        cur_iter <= cur_iter + 4'd1;
                    end
                end else begin
                    cur_idx <= cur_idx + 4'd1;
                end
            end else if (accept) begin
                rreq <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (load) begin
            req_tag.mat  <= cur_mat;
            req_tag.iter <= cur_is_b ? 4'd0 : cur_iter;
            req_tag.idx  <= cur_is_b ? 4'd0 : cur_idx;
            req_tag.is_b <= cur_is_b;
        end
    end

    gsim_sync_fifo #(.DATA_W(TAG_W), .DEPTH(DEPTH)) tag_fifo (
        .clk   (i_clk),
        .reset (i_reset),
        .push  (accept),
        .pop   (ret),
        .wdata (req_tag),
        .rdata (ret_tag),
        .count (tag_count)
    );

    gsim_sync_fifo #(.DATA_W(TAG_W + ROW_W), .DEPTH(DEPTH)) row_fifo (
        .clk   (i_clk),
        .reset (i_reset),
        .push  (ret),
        .pop   (pop),
        .wdata ({ret_tag, i_mem_dout}),
        .rdata (row_rdata),
        .count (row_count)
    );

    assign head_tag  = row_rdata[TAG_W+ROW_W-1:ROW_W];
    assign head_data = row_rdata[ROW_W-1:0];

    assign o_busy     = (state != S_IDLE);
    assign o_done     = (state == S_DONE);
    assign o_mem_rreq = rreq;
    assign o_mem_addr = addr;
    assign o_row_vld  = row_vld;
    assign o_row_data = row_vld ? head_data : '0;
    assign o_row_mat  = row_vld ? head_tag.mat : '0;
    assign o_row_iter = row_vld ? head_tag.iter : '0;
    assign o_row_idx  = row_vld ? head_tag.idx : '0;
    assign o_row_is_b = row_vld ? head_tag.is_b : 1'b0;

`ifndef SYNTHESIS
    always @(posedge i_clk) begin
        if (!i_reset) assert (!(i_mem_dout_vld && (state == S_IDLE || state == S_DONE)));
    end
`endif
endmodule

// File: tb/tb_gsim_row_fetcher.sv
// Bench for gsim_row_fetcher: memory model with variable latency, engine with variable
// ready, and a scoreboard of expected addresses and tagged rows.
module tb_gsim_row_fetcher;
    localparam int DEPTH = 4;

    logic         i_clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_start = 1'b0;
    logic [4:0]   i_matrix_num = 5'd0;
    logic         o_busy, o_done, o_mem_rreq;
    logic [9:0]   o_mem_addr;
    logic         i_mem_rrdy = 1'b0;
    logic [255:0] i_mem_dout = '0;
    logic         i_mem_dout_vld = 1'b0;
    logic         o_row_vld;
    logic         i_row_rdy = 1'b0;
    logic [255:0] o_row_data;
    logic [4:0]   o_row_mat;
    logic [3:0]   o_row_iter, o_row_idx;
    logic         o_row_is_b;

    always #5 i_clk = ~i_clk;

    gsim_row_fetcher dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_matrix_num(i_matrix_num),
        .o_busy(o_busy), .o_done(o_done), .o_mem_rreq(o_mem_rreq), .o_mem_addr(o_mem_addr),
        .i_mem_rrdy(i_mem_rrdy), .i_mem_dout(i_mem_dout), .i_mem_dout_vld(i_mem_dout_vld),
        .o_row_vld(o_row_vld), .i_row_rdy(i_row_rdy), .o_row_data(o_row_data),
        .o_row_mat(o_row_mat), .o_row_iter(o_row_iter), .o_row_idx(o_row_idx),
        .o_row_is_b(o_row_is_b)
    );

    typedef struct {
        int addr;
        int mat;
        int iter;
        int idx;
        int is_b;
    } exp_t;

    exp_t exp_row_q[$];
    int   exp_addr_q[$];
    int   ret_addr_q[$];
    int   ret_due_q[$];

    int checks = 0, failures = 0;
    int cyc = 0, last_due = 0, acc_cnt = 0, pop_cnt = 0, ret_cnt = 0, done_cnt = 0;
    int last_done_wait = 0;
    bit rreq_seen = 1'b0;
    bit rrdy_rand = 1'b0, rowrdy_rand = 1'b0, lat_rand = 1'b0;
    logic rrdy_fixed = 1'b1, rowrdy_fixed = 1'b1;
    int lat_fixed = 1;
    bit req_hold = 1'b0, row_hold = 1'b0;
    int hold_addr = 0;
    logic [255:0] hold_data = '0;
    logic [13:0]  hold_tag = '0;

    function automatic logic [255:0] row_pattern(input int a);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = {8'(i), 8'hC3, 6'd0, 10'(a)} ^ 32'(a * 977);
        return d;
    endfunction

    // Memory model, engine model and scoreboard; inputs change on the falling edge.
    always @(negedge i_clk) begin
        exp_t e;
        int   a;
        int   due;
        bit   accepted;
        cyc++;
        accepted = 1'b0;
        if (o_done === 1'b1) done_cnt++;
        if (o_mem_rreq === 1'b1) rreq_seen = 1'b1;
        if (!i_reset && req_hold) begin
            checks++;
            if (o_mem_rreq !== 1'b1 || o_mem_addr !== 10'(hold_addr)) begin
                failures++;
                $display("FAIL req_stable rreq=%0b addr=%0d required rreq=1 addr=%0d",
                         o_mem_rreq, o_mem_addr, hold_addr);
            end
        end
        if (!i_reset && row_hold) begin
            checks++;
            if (o_row_vld !== 1'b1 || {o_row_mat, o_row_iter, o_row_idx, o_row_is_b} !== hold_tag
                || o_row_data !== hold_data) begin
                failures++;
                $display("FAIL head_stable vld=%0b tag=%h required vld=1 tag=%h",
                         o_row_vld, {o_row_mat, o_row_iter, o_row_idx, o_row_is_b}, hold_tag);
            end
        end
        i_mem_rrdy = rrdy_rand ? 1'($urandom_range(0, 1)) : rrdy_fixed;
        i_row_rdy  = rowrdy_rand ? 1'($urandom_range(0, 1)) : rowrdy_fixed;
        if (ret_addr_q.size() != 0 && ret_due_q[0] <= cyc) begin
            i_mem_dout_vld = 1'b1;
            i_mem_dout     = row_pattern(ret_addr_q.pop_front());
            void'(ret_due_q.pop_front());
            ret_cnt++;
        end else begin
            i_mem_dout_vld = 1'b0;
            i_mem_dout     = '0;
        end
        req_hold = 1'b0;
        row_hold = 1'b0;
        if (!i_reset && o_mem_rreq === 1'b1) begin
            if (i_mem_rrdy) begin
                checks++;
                if (exp_addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL req_unexpected addr=%0d required no request", o_mem_addr);
                end else begin
                    a = exp_addr_q.pop_front();
                    if (o_mem_addr !== 10'(a)) begin
                        failures++;
                        $display("FAIL req_addr addr=%0d required %0d", o_mem_addr, a);
                    end
                end
                due = cyc + (lat_rand ? int'($urandom_range(1, 5)) : lat_fixed);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                ret_addr_q.push_back(int'(o_mem_addr));
                ret_due_q.push_back(due);
                acc_cnt++;
                accepted = 1'b1;
            end else begin
                req_hold  = 1'b1;
                hold_addr = int'(o_mem_addr);
            end
        end
        if (!i_reset && o_row_vld === 1'b1) begin
            if (i_row_rdy) begin
                checks++;
                if (exp_row_q.size() == 0) begin
                    failures++;
                    $display("FAIL row_unexpected tag=%h required no row",
                             {o_row_mat, o_row_iter, o_row_idx, o_row_is_b});
                end else begin
                    e = exp_row_q.pop_front();
                    if (o_row_mat !== 5'(e.mat) || o_row_iter !== 4'(e.iter) ||
                        o_row_idx !== 4'(e.idx) || o_row_is_b !== 1'(e.is_b) ||
                        o_row_data !== row_pattern(e.addr)) begin
                        failures++;
                        $display("FAIL row_out mat=%0d iter=%0d idx=%0d b=%0b data_ok=%0b required mat=%0d iter=%0d idx=%0d b=%0d addr=%0d",
                                 o_row_mat, o_row_iter, o_row_idx, o_row_is_b,
                                 o_row_data === row_pattern(e.addr), e.mat, e.iter, e.idx, e.is_b, e.addr);
                    end
                end
                pop_cnt++;
            end else begin
                row_hold  = 1'b1;
                hold_tag  = {o_row_mat, o_row_iter, o_row_idx, o_row_is_b};
                hold_data = o_row_data;
            end
        end
        if (accepted) begin
            checks++;
            if (acc_cnt - pop_cnt > DEPTH) begin
                failures++;
                $display("FAIL credit in_flight=%0d required <= %0d", acc_cnt - pop_cnt, DEPTH);
            end
        end
    end

    task automatic start_run(input int nmat);
        exp_t e;
        exp_row_q.delete();
        exp_addr_q.delete();
        for (int m = 0; m < nmat; m++) begin
            for (int k = 0; k <= 256; k++) begin
                if (k == 0) begin
                    e = '{addr: 17 * m + 16, mat: m, iter: 0, idx: 0, is_b: 1};
                end else begin
                    e = '{addr: 17 * m + (k - 1) % 16, mat: m, iter: (k - 1) / 16,
                          idx: (k - 1) % 16, is_b: 0};
                end
                exp_row_q.push_back(e);
                exp_addr_q.push_back(e.addr);
            end
        end
        @(negedge i_clk);
        i_matrix_num = 5'(nmat);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start busy=%0b required 1", o_busy);
        end
    endtask

    task automatic finish_run(input int budget);
        int c;
        int d0;
        d0 = done_cnt;
        c = 0;
        while (o_done !== 1'b1 && c < budget) begin
            @(negedge i_clk);
            c++;
        end
        last_done_wait = c;
        checks++;
        if (o_done !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout done=%0b after %0d cycles required 1", o_done, c);
        end
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL after_done busy=%0b done=%0b required 0 0", o_busy, o_done);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL done_pulses count=%0d required 1", done_cnt - d0);
        end
        checks++;
        if (exp_row_q.size() != 0 || exp_addr_q.size() != 0) begin
            failures++;
            $display("FAIL leftover rows=%0d addrs=%0d required 0 0",
                     exp_row_q.size(), exp_addr_q.size());
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_busy, o_done, o_mem_rreq, o_row_vld, o_row_is_b} !== 5'b0 || o_mem_addr !== 10'd0 ||
            o_row_data !== 256'd0 || {o_row_mat, o_row_iter, o_row_idx} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs busy=%0b done=%0b rreq=%0b addr=%0d vld=%0b required all 0",
                     o_busy, o_done, o_mem_rreq, o_mem_addr, o_row_vld);
        end
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
        checks++;
        if ({o_busy, o_done, o_mem_rreq, o_row_vld} !== 4'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%0b done=%0b rreq=%0b vld=%0b required 0",
                     o_busy, o_done, o_mem_rreq, o_row_vld);
        end
    endtask

    task automatic test_single();
        rrdy_fixed = 1'b1; rowrdy_fixed = 1'b1; lat_fixed = 1;
        start_run(1);
        finish_run(3000);
    endtask

    task automatic test_two();
        rrdy_fixed = 1'b1; rowrdy_fixed = 1'b1; lat_fixed = 1;
        start_run(2);
        finish_run(5000);
    endtask

    task automatic test_backpressure();
        int a0;
        rrdy_fixed = 1'b1; rowrdy_fixed = 1'b0; lat_fixed = 3;
        a0 = acc_cnt;
        start_run(1);
        repeat (20) @(negedge i_clk);
        checks++;
        if (acc_cnt - a0 != 4) begin
            failures++;
            $display("FAIL bp_accepted count=%0d required 4", acc_cnt - a0);
        end
        checks++;
        if (o_mem_rreq !== 1'b0) begin
            failures++;
            $display("FAIL bp_rreq rreq=%0b required 0", o_mem_rreq);
        end
        checks++;
        if (o_row_vld !== 1'b1 || o_row_is_b !== 1'b1 || o_row_data !== row_pattern(16)) begin
            failures++;
            $display("FAIL bp_head vld=%0b is_b=%0b data_ok=%0b required 1 1 1",
                     o_row_vld, o_row_is_b, o_row_data === row_pattern(16));
        end
        rowrdy_fixed = 1'b1;
        finish_run(3000);
    endtask

    task automatic test_random();
        rrdy_rand = 1'b1; rowrdy_rand = 1'b1; lat_rand = 1'b1;
        start_run(1);
        repeat (40) @(negedge i_clk);
        i_matrix_num = 5'd7;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL start_in_run busy=%0b done=%0b required 1 0", o_busy, o_done);
        end
        finish_run(12000);
        rrdy_rand = 1'b0; rowrdy_rand = 1'b0; lat_rand = 1'b0;
    endtask

    task automatic test_zero();
        rreq_seen = 1'b0;
        start_run(0);
        finish_run(10);
        checks++;
        if (last_done_wait > 1 || rreq_seen) begin
            failures++;
            $display("FAIL zero_matrices wait=%0d rreq_seen=%0b required <=1 0",
                     last_done_wait, rreq_seen);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        rrdy_fixed = 1'b1; rowrdy_fixed = 1'b1; lat_fixed = 3;
        acc_cnt = 0; ret_cnt = 0; pop_cnt = 0;
        start_run(1);
        c = 0;
        do begin
            @(negedge i_clk);
            #1;
            c++;
        end while (acc_cnt - ret_cnt != 2 && c < 50);
        checks++;
        if (acc_cnt - ret_cnt != 2) begin
            failures++;
            $display("FAIL mid_outstanding count=%0d required 2", acc_cnt - ret_cnt);
        end
        i_reset = 1'b1;
        #1;
        checks++;
        if ({o_busy, o_done, o_mem_rreq, o_row_vld, o_row_is_b} !== 5'b0 || o_mem_addr !== 10'd0 ||
            o_row_data !== 256'd0 || {o_row_mat, o_row_iter, o_row_idx} !== 13'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs busy=%0b rreq=%0b addr=%0d vld=%0b required all 0",
                     o_busy, o_mem_rreq, o_mem_addr, o_row_vld);
        end
        repeat (8) @(negedge i_clk);
        #1;
        exp_row_q.delete(); exp_addr_q.delete();
        ret_addr_q.delete(); ret_due_q.delete();
        last_due = cyc; acc_cnt = 0; pop_cnt = 0; ret_cnt = 0;
        i_reset = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_busy, o_mem_rreq, o_row_vld} !== 3'b0) begin
            failures++;
            $display("FAIL late_return busy=%0b rreq=%0b vld=%0b required 0 0 0",
                     o_busy, o_mem_rreq, o_row_vld);
        end
        start_run(1);
        finish_run(3000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_two();
        test_backpressure();
        test_random();
        test_zero();
        test_reset_mid();
        repeat (2) @(negedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
